// File: rtl/timer_ctrl_if.sv
// Configuration, control and status bundle for timer_ctrl.
// The master drives config/control and observes status; the timer is the slave.
interface timer_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             cfg_we;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_auto;
  logic             start;
  logic             stop;
  logic             irq_ack;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic [1:0]       state;
  logic             irq;
  logic             ovr;

  modport master (
    output cfg_we, cfg_period, cfg_auto, start, stop, irq_ack,
    input  count, busy, state, irq, ovr
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_auto, start, stop, irq_ack,
    output count, busy, state, irq, ovr
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable down-counting timer with one-shot / auto-reload modes and
// sticky terminal-count (irq) and overrun (ovr) flags.
//
// state | meaning
// IDLE  | stopped; waits for start with a non-zero period
// LOAD  | one cycle; count takes the configured period
// RUN   | count decrements; reaching the end fires the terminal event
// DONE  | one cycle at count 0; reload or return to IDLE
module timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_auto;
  logic             r_busy;
  logic             r_irq;
  logic             r_ovr;
  logic             w_term;

  // <= 1 rather than == 1 so a zero period loaded mid-operation can never wrap
  assign w_term = (r_state == RUN) && !bus.stop && (r_count <= WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_period <= '0;
      r_auto   <= 1'b0;
      r_busy   <= 1'b0;
      r_irq    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        r_period <= bus.cfg_period;
        r_auto   <= bus.cfg_auto;
      end

      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop && (r_period != '0)) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_count <= r_period;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            r_count <= '0;
            r_state <= DONE;
          end else begin
            r_count <= r_count - WIDTH'(1);
          end
        end
        DONE: begin
          if (bus.stop || !r_auto) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= LOAD;
          end
        end
      endcase

      // a terminal event on the ack edge wins for irq but still clears ovr
      if (w_term) begin
        r_irq <= 1'b1;
        if (bus.irq_ack)
          r_ovr <= 1'b0;
        else if (r_irq)
          r_ovr <= 1'b1;
      end else if (bus.irq_ack) begin
        r_irq <= 1'b0;
        r_ovr <= 1'b0;
      end
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.state = r_state;
  assign bus.irq   = r_irq;
  assign bus.ovr   = r_ovr;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed multi-cycle
// sequences and random stimulus against an elapsed-time reference model.
module tb_timer_ctrl;
  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic clk = 1'b0;
  logic reset;
  timer_ctrl_if #(.WIDTH(W)) bus ();

  timer_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: time elapsed within the current load/run/done segment.
  bit         m_valid = 0;
  bit         m_act;
  int         m_el;
  int         m_seg;
  logic [W-1:0] m_cnt;
  logic [W-1:0] m_per;
  bit         m_auto;
  bit         m_irq;
  bit         m_ovr;

  function automatic void model_edge(input bit rst_n, input bit we, input logic [W-1:0] per,
                                     input bit au, input bit st, input bit sp, input bit ack);
    bit term;
    int eln;
    if (!rst_n) begin
      m_valid = 1; m_act = 0; m_el = 0; m_seg = 0; m_cnt = '0;
      m_per = '0; m_auto = 0; m_irq = 0; m_ovr = 0;
      return;
    end
    term = 0;
    if (!m_act) begin
      if (st && !sp && (m_per != 0)) begin
        m_act = 1;
        m_el  = 0;
      end
    end else if (sp) begin
      m_act = 0;
    end else begin
      if (m_el == 0) m_seg = int'(m_per);
      eln = m_el + 1;
      if (eln <= m_seg) begin
        m_cnt = W'(m_seg - eln + 1);
        m_el  = eln;
      end else if (eln == m_seg + 1) begin
        m_cnt = '0;
        term  = 1;
        m_el  = eln;
      end else if (m_auto) begin
        m_el = 0;
      end else begin
        m_act = 0;
      end
    end
    if (term) begin
      if (ack) m_ovr = 0;
      else if (m_irq) m_ovr = 1;
      m_irq = 1;
    end else if (ack) begin
      m_irq = 0;
      m_ovr = 0;
    end
    if (we) begin
      m_per  = per;
      m_auto = au;
    end
  endfunction

  function automatic logic [1:0] m_state();
    if (!m_act) return S_IDLE;
    if (m_el == 0) return S_LOAD;
    if (m_el <= m_seg) return S_RUN;
    return S_DONE;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] c, input logic [1:0] s,
                     input bit b, input bit i, input bit o);
    n_chk++;
    if (bus.count !== c || bus.state !== s || bus.busy !== b || bus.irq !== i || bus.ovr !== o) begin
      n_err++;
      $display("FAIL %s: got count=%0d state=%0d busy=%0d irq=%0d ovr=%0d, required count=%0d state=%0d busy=%0d irq=%0d ovr=%0d",
               nm, bus.count, bus.state, bus.busy, bus.irq, bus.ovr, c, s, b, i, o);
    end
  endtask

  // drive one cycle of inputs, advance the model, compare after the edge
  task automatic step(input bit rst_n, input bit we, input logic [W-1:0] per,
                      input bit au, input bit st, input bit sp, input bit ack);
    reset          = rst_n;
    bus.cfg_we     = we;
    bus.cfg_period = per;
    bus.cfg_auto   = au;
    bus.start      = st;
    bus.stop       = sp;
    bus.irq_ack    = ack;
    model_edge(rst_n, we, per, au, st, sp, ack);
    @(posedge clk);
    #1;
    if (m_valid) chk("model", m_cnt, m_state(), m_act, m_irq, m_ovr);
  endtask

  typedef struct {
    bit           rst_n;
    bit           we;
    logic [W-1:0] per;
    bit           au;
    bit           st;
    bit           sp;
    bit           ack;
    logic [W-1:0] e_cnt;
    logic [1:0]   e_st;
    bit           e_busy;
    bit           e_irq;
    bit           e_ovr;
  } vec_t;

  vec_t vt[$];

  function automatic void av(input bit r, input bit we, input int per, input bit au,
                             input bit st, input bit sp, input bit ack, input int ec,
                             input logic [1:0] es, input bit eb, input bit ei, input bit eo);
    vec_t v;
    v = '{r, we, W'(per), au, st, sp, ack, W'(ec), es, eb, ei, eo};
    vt.push_back(v);
  endfunction

  initial begin
    reset = 1'b0;
    bus.cfg_we = 0; bus.cfg_period = '0; bus.cfg_auto = 0;
    bus.start = 0; bus.stop = 0; bus.irq_ack = 0;

    //   rst we per au st sp ack | cnt state busy irq ovr
    av(0, 0,  0, 0, 0, 0, 0,   0, S_IDLE, 0, 0, 0);
    av(0, 0,  0, 0, 0, 0, 0,   0, S_IDLE, 0, 0, 0);
    av(1, 1,  3, 0, 0, 0, 0,   0, S_IDLE, 0, 0, 0);
    av(1, 0,  0, 0, 1, 0, 0,   0, S_LOAD, 1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   3, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   2, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   1, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   0, S_DONE, 1, 1, 0);
    av(1, 0,  0, 0, 0, 0, 0,   0, S_IDLE, 0, 1, 0);
    av(1, 0,  0, 0, 0, 0, 1,   0, S_IDLE, 0, 0, 0);
    av(1, 1,  1, 0, 0, 0, 0,   0, S_IDLE, 0, 0, 0);
    av(1, 0,  0, 0, 1, 0, 0,   0, S_LOAD, 1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   1, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   0, S_DONE, 1, 1, 0);
    av(1, 0,  0, 0, 0, 0, 0,   0, S_IDLE, 0, 1, 0);
    av(1, 1,  0, 0, 0, 0, 0,   0, S_IDLE, 0, 1, 0);
    av(1, 0,  0, 0, 1, 0, 0,   0, S_IDLE, 0, 1, 0);
    av(1, 0,  0, 0, 1, 0, 1,   0, S_IDLE, 0, 0, 0);
    av(1, 1, 10, 0, 0, 0, 0,   0, S_IDLE, 0, 0, 0);
    av(1, 0,  0, 0, 1, 0, 0,   0, S_LOAD, 1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,  10, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 1, 0, 0,   9, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   8, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   7, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   6, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   5, S_RUN,  1, 0, 0);
    av(1, 0,  0, 0, 1, 1, 0,   5, S_IDLE, 0, 0, 0);
    av(1, 0,  0, 0, 0, 0, 0,   5, S_IDLE, 0, 0, 0);
    av(1, 0,  0, 0, 1, 0, 0,   5, S_LOAD, 1, 0, 0);
    av(1, 0,  0, 0, 0, 1, 0,   5, S_IDLE, 0, 0, 0);

    @(posedge clk);
    #1;
    foreach (vt[k]) begin
      step(vt[k].rst_n, vt[k].we, vt[k].per, vt[k].au, vt[k].st, vt[k].sp, vt[k].ack);
      chk($sformatf("vec%0d", k), vt[k].e_cnt, vt[k].e_st, vt[k].e_busy, vt[k].e_irq, vt[k].e_ovr);
    end

    // reset held two cycles mid-RUN at count 7, with irq pending beforehand
    step(1, 1, 1, 0, 1, 0, 0);
    for (int e = 0; e < 3; e++) step(1, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_irq", 0, S_IDLE, 0, 1, 0);
    step(1, 1, 9, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    for (int e = 0; e < 3; e++) step(1, 0, 0, 0, 0, 0, 0);
    chk("run_at_7", 7, S_RUN, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("reset_mid_run", 0, S_IDLE, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    chk("start_after_reset", 0, S_IDLE, 0, 0, 0);

    // auto-reload, period 2: overrun, ack, ack colliding with a terminal
    step(1, 1, 2, 1, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      step(1, 0, 0, 0, 0, (e == 16), (e == 8 || e == 15));
      if (e == 3)  chk("auto_term1", 0, S_DONE, 1, 1, 0);
      if (e == 6)  chk("auto_pre_ovr", 1, S_RUN, 1, 1, 0);
      if (e == 7)  chk("auto_ovr", 0, S_DONE, 1, 1, 1);
      if (e == 8)  chk("auto_ack", 0, S_LOAD, 1, 0, 0);
      if (e == 9)  chk("auto_reload", 2, S_RUN, 1, 0, 0);
      if (e == 11) chk("auto_term3", 0, S_DONE, 1, 1, 0);
      if (e == 15) chk("ack_on_term", 0, S_DONE, 1, 1, 0);
      if (e == 16) chk("auto_stop", 0, S_IDLE, 0, 1, 0);
    end

    // reconfigure mid-RUN: period 8 running, period 3 written at count 6
    step(1, 1, 8, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0);
    for (int e = 1; e <= 11; e++) begin
      step(1, (e == 4), 3, 1, 0, 0, 0);
      if (e == 3)  chk("reconf_at_6", 6, S_RUN, 1, 0, 0);
      if (e == 8)  chk("reconf_cnt1", 1, S_RUN, 1, 0, 0);
      if (e == 9)  chk("reconf_done", 0, S_DONE, 1, 1, 0);
      if (e == 10) chk("reconf_load", 0, S_LOAD, 1, 1, 0);
      if (e == 11) chk("reconf_new_period", 3, S_RUN, 1, 1, 0);
    end
    step(1, 0, 0, 0, 0, 1, 1);

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(299) != 0),
           ($urandom_range(15) == 0),
           W'($urandom_range(6, 1)),
           ($urandom_range(1) == 1),
           ($urandom_range(3) == 0),
           ($urandom_range(19) == 0),
           ($urandom_range(7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
